pcm_out_fifo: RTL and testbench
===============================

# pcm_out_fifo

Output stage of the MCD PCM path. It captures each stereo sample from the 8‑channel PCM mixer (`pcm_vol_l`/`pcm_vol_r`, qualified by `pcm_sync`) and smooths it with a per‑side first‑order IIR low‑pass. The result is buffered in a small FIFO so the downstream audio mixer can pull samples at its own rate through a request/valid strobe pair. This decouples the sub‑CPU‑derived PCM sample rate from the output mixer rate and reports overflow and underflow.

## Interface
Parameters:
- `DEPTH_LOG2`, 2: FIFO depth is 2^DEPTH_LOG2 stereo entries.
- `FILT_SH`, 1: IIR shift; 0 = filter bypass, legal range 0..4.

Ports:
- `clk_asic`  in  1  single clock. All state updates on the falling edge, matching the rest of the MCD audio path.
- `rst`  in  1  synchronous, active‑high reset.
- `sub_sync`  in  1  sub‑CPU clock enable; qualifies the capture side.
- `pcm_sync`  in  1  PCM sample tick, high while the sampler counter is 0.
- `pcm_vol_l`  in  16  signed left sample from the PCM mixer.
- `pcm_vol_r`  in  16  signed right sample from the PCM mixer.
- `snd_req`  in  1  pop request from the output mixer; single‑cycle strobe, any rate.
- `flag_clr`  in  1  clears `ovf` and `udf`.
- `snd_l`  out  16  signed left output sample, registered.
- `snd_r`  out  16  signed right output sample, registered.
- `snd_vld`  out  1  one‑cycle strobe answering each `snd_req`.
- `fifo_lvl`  out  DEPTH_LOG2+1  current occupancy.
- `ovf`  out  1  sticky; a capture was dropped because the FIFO was full.
- `udf`  out  1  sticky; a request was served while the FIFO was empty.

## Operation
- **Capture event:** `cap = sub_sync & pcm_sync`. This is true for exactly one `clk_asic` cycle per PCM sample period (48 `sub_sync` ticks).
- **Filter:** for each side independently, on `cap`: `y <= y + ((x - y) >>> FILT_SH)`.
  - `x - y` is computed at 17 bits signed with arithmetic shift.
  - The sum is truncated to 16 bits. It cannot overflow because `y` stays within [min(x), max(x)].
  - With `FILT_SH = 0`, `y <= x`.
- **Push:** one cycle after `cap`, `push_pend` writes `{y_l, y_r}` at the write pointer, unless the FIFO is full.
  - If full, the new sample is dropped (the oldest data is kept) and `ovf` is set.
- **Pop:** on `snd_req`:
  - If `fifo_lvl != 0`: the entry at the read pointer is loaded into `snd_l`/`snd_r`, the read pointer advances, and the level decrements.
  - If `fifo_lvl == 0`: `snd_l`/`snd_r` hold their previous value and `udf` is set.
  - In both cases `snd_vld` pulses on the next cycle.
- **Simultaneous push and pop:**
  - FIFO full: the pop frees the slot, the push is accepted, the level is unchanged, and `ovf` is not set.
  - FIFO empty: the pop underflows using the held value, the push is accepted, and the level becomes 1. There is no bypass.
- **Pointers:** DEPTH_LOG2 bits wide, wrapping modulo depth. `fifo_lvl` is kept as a separate counter (0..2^DEPTH_LOG2).
- **Flags:** `flag_clr` has priority over setting in the same cycle.
- **Reset:** the following are all cleared to 0:
  - `snd_l`, `snd_r`, `snd_vld`, `fifo_lvl`, `ovf`, `udf`
  - both filter states, both pointers, `push_pend`
  
  Reset mid‑operation discards pending pushes and buffered data. The first `cap` after reset filters from y = 0.

## Timing
- **Capture to FIFO:** `cap` at falling edge N updates `y`. Edge N+1 writes the FIFO and `fifo_lvl` increments, visible after N+1.
- **Request to data:** `snd_req` sampled at edge M. `snd_l`/`snd_r` update and `snd_vld = 1` after M, `snd_vld` deasserts after M+1.
- **Back‑to‑back requests:** `snd_req` on consecutive cycles yields consecutive entries and `snd_vld` high on consecutive cycles.
- **Filter cadence:** no per‑cycle dependence on `sub_sync` other than `cap`. The filter advances only on `cap`.
- **Latency bounds:** minimum 2 edges from `cap` to a sample being poppable. Maximum residence is depth × requester period.

## Test plan
- **Reset defaults:** hold `rst` 3 cycles, then release. Expect all outputs 0. `snd_req` with an empty FIFO gives `snd_l = snd_r = 0`, `snd_vld` pulses, and `udf = 1`.
- **Filter step:** `FILT_SH = 1`, `pcm_vol_l = 16'h4000`, `pcm_vol_r = -16'h4000`, 3 captures. Popped L = 0x2000, 0x3000, 0x3800 and R = -0x2000, -0x3000, -0x3800.
- **Overflow:** depth 4, bypass filter, 6 captures of values 1..6 with no pops. Expect `fifo_lvl = 4` and `ovf = 1`; pops return 1, 2, 3, 4. Then `flag_clr` makes `ovf = 0`.
- **Full collision:** FIFO full; assert `snd_req` in the same cycle as `push_pend`. Expect `fifo_lvl` stays 4, `ovf` stays 0, and the oldest value is returned.
- **Empty collision:** FIFO empty, last output 0x1234; `snd_req` coincides with push of 0x0555. Expect `snd_l = 0x1234`, `udf = 1`, `fifo_lvl = 1`, and the next pop returns 0x0555.
- **Reset mid‑stream:** 3 entries buffered; pulse `rst` one cycle. Expect `fifo_lvl = 0` and filter state 0. The next capture of 0x0100 with `FILT_SH = 1` pops 0x0080.

Source files
------------

// File: rtl/pcm_out_fifo.sv
// PCM output stage: per-side first-order IIR low-pass on each PCM capture,
// buffered in a small stereo FIFO popped by the output mixer via snd_req/snd_vld.
module pcm_out_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned FILT_SH    = 1
) (
    input  logic                  clk_asic,
    input  logic                  rst,
    input  logic                  sub_sync,
    input  logic                  pcm_sync,
    input  logic [15:0]           pcm_vol_l,
    input  logic [15:0]           pcm_vol_r,
    input  logic                  snd_req,
    input  logic                  flag_clr,
    output logic [15:0]           snd_l,
    output logic [15:0]           snd_r,
    output logic                  snd_vld,
    output logic [DEPTH_LOG2:0]   fifo_lvl,
    output logic                  ovf,
    output logic                  udf
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic                 cap;
    logic [15:0]          y_l;
    logic [15:0]          y_r;
    logic signed [16:0]   d_l;
    logic signed [16:0]   d_r;
    logic signed [16:0]   s_l;
    logic signed [16:0]   s_r;
    logic                 push_pend;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [31:0]          mem [DEPTH];
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;

    assign cap = sub_sync & pcm_sync;

    // 17-bit signed difference keeps x - y exact before the arithmetic shift
    always_comb begin
        d_l = {pcm_vol_l[15], pcm_vol_l} - {y_l[15], y_l};
        d_r = {pcm_vol_r[15], pcm_vol_r} - {y_r[15], y_r};
        s_l = d_l >>> FILT_SH;
        s_r = d_r >>> FILT_SH;
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        full    = (fifo_lvl == LW'(DEPTH));
        empty   = (fifo_lvl == '0);
        pop     = snd_req & ~empty;
        push_ok = push_pend & (~full | pop);
        drop    = push_pend & full & ~pop;
    end

    always_ff @(negedge clk_asic) begin
        if (rst) begin
            y_l       <= '0;
            y_r       <= '0;
            push_pend <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_lvl  <= '0;
            snd_l     <= '0;
            snd_r     <= '0;
            snd_vld   <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            push_pend <= cap;
            snd_vld   <= snd_req;
            if (cap) begin
                y_l <= y_l + s_l[15:0];
                y_r <= y_r + s_r[15:0];
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                snd_l  <= mem[rd_ptr][31:16];
                snd_r  <= mem[rd_ptr][15:0];
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_lvl <= fifo_lvl + LW'(1);
                2'b01:   fifo_lvl <= fifo_lvl - LW'(1);
                default: fifo_lvl <= fifo_lvl;
            endcase
            if (flag_clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (drop) begin
                    ovf <= 1'b1;
                end
                if (snd_req & empty) begin
                    udf <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid
    always_ff @(negedge clk_asic) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= {y_l, y_r};
        end
    end

endmodule

// File: tb/tb_pcm_out_fifo.sv
// Directed bench for pcm_out_fifo: one filtered instance (FILT_SH=1) and one
// bypass instance (FILT_SH=0) share stimulus; each test checks the relevant one.
module tb_pcm_out_fifo;

    logic        clk_asic;
    logic        rst;
    logic        sub_sync;
    logic        pcm_sync;
    logic [15:0] pcm_vol_l;
    logic [15:0] pcm_vol_r;
    logic        snd_req;
    logic        flag_clr;

    logic [15:0] f_snd_l, f_snd_r, b_snd_l, b_snd_r;
    logic        f_snd_vld, b_snd_vld, f_ovf, b_ovf, f_udf, b_udf;
    logic [2:0]  f_lvl, b_lvl;

    int checks = 0;
    int errors = 0;

    pcm_out_fifo #(.DEPTH_LOG2(2), .FILT_SH(1)) u_f (
        .clk_asic(clk_asic), .rst(rst), .sub_sync(sub_sync), .pcm_sync(pcm_sync),
        .pcm_vol_l(pcm_vol_l), .pcm_vol_r(pcm_vol_r), .snd_req(snd_req),
        .flag_clr(flag_clr), .snd_l(f_snd_l), .snd_r(f_snd_r), .snd_vld(f_snd_vld),
        .fifo_lvl(f_lvl), .ovf(f_ovf), .udf(f_udf)
    );

    pcm_out_fifo #(.DEPTH_LOG2(2), .FILT_SH(0)) u_b (
        .clk_asic(clk_asic), .rst(rst), .sub_sync(sub_sync), .pcm_sync(pcm_sync),
        .pcm_vol_l(pcm_vol_l), .pcm_vol_r(pcm_vol_r), .snd_req(snd_req),
        .flag_clr(flag_clr), .snd_l(b_snd_l), .snd_r(b_snd_r), .snd_vld(b_snd_vld),
        .fifo_lvl(b_lvl), .ovf(b_ovf), .udf(b_udf)
    );

    initial begin
        clk_asic = 1'b0;
        forever #5 clk_asic = ~clk_asic;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One falling (active) edge, then sample after the following rising edge
    task automatic tick();
        @(negedge clk_asic);
        @(posedge clk_asic);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic capture(input logic [15:0] l, input logic [15:0] r);
        pcm_vol_l = l;
        pcm_vol_r = r;
        sub_sync  = 1'b1;
        pcm_sync  = 1'b1;
        tick();
        sub_sync  = 1'b0;
        pcm_sync  = 1'b0;
        tick();
    endtask

    task automatic pop();
        snd_req = 1'b1;
        tick();
        snd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sub_sync = 1'b0; pcm_sync = 1'b0;
        pcm_vol_l = '0; pcm_vol_r = '0; snd_req = 1'b0; flag_clr = 1'b0;
        @(posedge clk_asic);
        #1;

        // Reset defaults
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_snd_l", 32'(f_snd_l), 32'h0);
        check("rst_snd_r", 32'(f_snd_r), 32'h0);
        check("rst_vld", 32'(f_snd_vld), 32'h0);
        check("rst_lvl", 32'(f_lvl), 32'h0);
        check("rst_ovf", 32'(f_ovf), 32'h0);
        check("rst_udf", 32'(f_udf), 32'h0);
        pop();
        check("udf0_vld", 32'(f_snd_vld), 32'h1);
        check("udf0_snd_l", 32'(f_snd_l), 32'h0);
        check("udf0_snd_r", 32'(f_snd_r), 32'h0);
        check("udf0_udf", 32'(f_udf), 32'h1);
        tick();
        check("udf0_vld_drop", 32'(f_snd_vld), 32'h0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("udf0_clr", 32'(f_udf), 32'h0);

        // Filter step response, FILT_SH=1
        reset_pulse();
        capture(16'h4000, 16'hC000);
        check("filt_lvl1", 32'(f_lvl), 32'h1);
        capture(16'h4000, 16'hC000);
        capture(16'h4000, 16'hC000);
        check("filt_lvl3", 32'(f_lvl), 32'h3);
        pop();
        check("filt_l0", 32'(f_snd_l), 32'h2000);
        check("filt_r0", 32'(f_snd_r), 32'hE000);
        pop();
        check("filt_l1", 32'(f_snd_l), 32'h3000);
        check("filt_r1", 32'(f_snd_r), 32'hD000);
        pop();
        check("filt_l2", 32'(f_snd_l), 32'h3800);
        check("filt_r2", 32'(f_snd_r), 32'hC800);
        check("filt_udf", 32'(f_udf), 32'h0);

        // Overflow with bypass filter, then back-to-back pops
        reset_pulse();
        for (int i = 1; i <= 6; i++) begin
            capture(16'(i), 16'(i + 16'h0100));
        end
        check("ovf_lvl", 32'(b_lvl), 32'h4);
        check("ovf_set", 32'(b_ovf), 32'h1);
        snd_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("ovf_pop_l", 32'(b_snd_l), 32'(i));
            check("ovf_pop_r", 32'(b_snd_r), 32'(i + 16'h0100));
            check("ovf_pop_vld", 32'(b_snd_vld), 32'h1);
        end
        snd_req = 1'b0;
        check("ovf_lvl_after", 32'(b_lvl), 32'h0);
        check("ovf_no_udf", 32'(b_udf), 32'h0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("ovf_clr", 32'(b_ovf), 32'h0);

        // Full collision: pop coincides with push_pend
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            capture(16'(16'h0011 + i), 16'h0000);
        end
        check("fc_full", 32'(b_lvl), 32'h4);
        pcm_vol_l = 16'h0015;
        sub_sync = 1'b1; pcm_sync = 1'b1;
        tick();
        sub_sync = 1'b0; pcm_sync = 1'b0; snd_req = 1'b1;
        tick();
        snd_req = 1'b0;
        check("fc_lvl", 32'(b_lvl), 32'h4);
        check("fc_ovf", 32'(b_ovf), 32'h0);
        check("fc_oldest", 32'(b_snd_l), 32'h0011);
        check("fc_vld", 32'(b_snd_vld), 32'h1);
        for (int i = 0; i < 4; i++) begin
            pop();
            check("fc_drain", 32'(b_snd_l), 32'(16'h0012 + i));
        end

        // Empty collision: underflow uses held value, push still lands
        reset_pulse();
        capture(16'h1234, 16'h4321);
        pop();
        check("ec_prev", 32'(b_snd_l), 32'h1234);
        check("ec_lvl0", 32'(b_lvl), 32'h0);
        pcm_vol_l = 16'h0555; pcm_vol_r = 16'h0AAA;
        sub_sync = 1'b1; pcm_sync = 1'b1;
        tick();
        sub_sync = 1'b0; pcm_sync = 1'b0; snd_req = 1'b1;
        tick();
        snd_req = 1'b0;
        check("ec_hold_l", 32'(b_snd_l), 32'h1234);
        check("ec_udf", 32'(b_udf), 32'h1);
        check("ec_lvl1", 32'(b_lvl), 32'h1);
        check("ec_vld", 32'(b_snd_vld), 32'h1);
        pop();
        check("ec_next_l", 32'(b_snd_l), 32'h0555);
        check("ec_next_r", 32'(b_snd_r), 32'h0AAA);

        // Reset mid-stream clears buffer and filter state
        reset_pulse();
        capture(16'h0400, 16'h0400);
        capture(16'h0400, 16'h0400);
        capture(16'h0400, 16'h0400);
        check("rm_lvl3", 32'(f_lvl), 32'h3);
        reset_pulse();
        check("rm_lvl0", 32'(f_lvl), 32'h0);
        check("rm_snd_l0", 32'(f_snd_l), 32'h0);
        capture(16'h0100, 16'hFF00);
        check("rm_lvl1", 32'(f_lvl), 32'h1);
        pop();
        check("rm_pop_l", 32'(f_snd_l), 32'h0080);
        check("rm_pop_r", 32'(f_snd_r), 32'hFF80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
